// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier between two requesters. Result follows 1 cycle after the multiplier's valid edge.
// One op in flight: requests stall while the multiplier is busy or a response waits on its ready.
module booth_arbiter #(
    parameter int NB      = 4,
    parameter int TIMEOUT = 4*NB+8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [NB-1:0]   req0_m,
    input  logic [NB-1:0]   req0_q,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [NB-1:0]   req1_m,
    input  logic [NB-1:0]   req1_q,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [2*NB-1:0] resp0_p,
    output logic            resp0_err,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [2*NB-1:0] resp1_p,
    output logic            resp1_err,
    output logic            mul_start,
    output logic [NB-1:0]   mul_m,
    output logic [NB-1:0]   mul_q,
    input  logic            mul_valid,
    input  logic [2*NB-1:0] mul_o
);
    localparam int CW = $clog2(TIMEOUT+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [NB-1:0]   m_reg;
    logic [NB-1:0]   q_reg;
    logic [2*NB-1:0] p_reg;
    logic            err;
    logic            owner;
    logic            last;
    logic            valid_d;
    logic [CW-1:0]   cnt;
    logic            any_req;
    logic            grant;
    logic            done_edge;
    logic            resp_taken;

    assign any_req = req0_valid | req1_valid;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == S_IDLE) && any_req && !grant;
    assign req1_ready = (state == S_IDLE) && any_req &&  grant;

    // valid_d resets high so a level left high by the multiplier is not taken as completion.
    assign done_edge  = mul_valid & ~valid_d;
    assign resp_taken = owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            m_reg   <= '0;
            q_reg   <= '0;
            p_reg   <= '0;
            err     <= 1'b0;
            owner   <= 1'b0;
            last    <= 1'b1;
            valid_d <= 1'b1;
            cnt     <= '0;
        end else begin
            valid_d <= mul_valid;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        m_reg <= grant ? req1_m : req0_m;
                        q_reg <= grant ? req1_q : req0_q;
                        owner <= grant;
                        last  <= grant;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (done_edge) begin
                        p_reg <= mul_o;
                        err   <= 1'b0;
                        state <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        p_reg <= '0;
                        err   <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (resp_taken)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_start = (state == S_ISSUE);
    assign mul_m     = m_reg;
    assign mul_q     = q_reg;

    assign resp0_valid = (state == S_RESP) && !owner;
    assign resp1_valid = (state == S_RESP) &&  owner;
    assign resp0_p     = resp0_valid ? p_reg : '0;
    assign resp1_p     = resp1_valid ? p_reg : '0;
    assign resp0_err   = resp0_valid & err;
    assign resp1_err   = resp1_valid & err;

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter with a behavioural multiplier of adjustable latency that can also hold valid stuck high.
module tb_booth_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic       resp0_valid, resp1_valid;
    logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [7:0] resp0_p, resp1_p;
    logic       resp0_err, resp1_err;
    logic       mul_start;
    logic [3:0] mul_m, mul_q;
    logic       mul_valid;
    logic [7:0] mul_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_arbiter #(.NB(4), .TIMEOUT(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_q(req0_q),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_q(req1_q),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_p(resp0_p), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_p(resp1_p), .resp1_err(resp1_err),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_valid(mul_valid), .mul_o(mul_o)
    );

    function automatic logic [7:0] prod(input logic [3:0] m, input logic [3:0] q);
        logic signed [7:0] a, b;
        a = {{4{m[3]}}, m};
        b = {{4{q[3]}}, q};
        return a * b;
    endfunction

    // Multiplier model: valid drops on start and rises lat cycles later with the product.
    int   lat   = 3;
    bit   stuck = 1'b0;
    logic mv    = 1'b0;
    logic [7:0] mo = '0;
    int   mcnt  = 0;
    assign mul_valid = stuck | mv;
    assign mul_o     = mo;
    always @(posedge clk) begin
        if (mul_start) begin
            mv   <= 1'b0;
            mcnt <= lat;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mv <= 1'b1;
                mo <= prod(mul_m, mul_q);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int port);
        return (port == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rvld_of(input int port);
        return (port == 0) ? resp0_valid : resp1_valid;
    endfunction

    function automatic logic [31:0] all_outs();
        return {req0_ready, req1_ready, resp0_valid, resp0_p, resp0_err,
                resp1_valid, resp1_p, resp1_err, mul_start, mul_m, mul_q};
    endfunction

    task automatic raise(input int port, input logic [3:0] m, input logic [3:0] q);
        if (port == 0) begin
            req0_valid = 1'b1; req0_m = m; req0_q = q;
        end else begin
            req1_valid = 1'b1; req1_m = m; req1_q = q;
        end
    endtask

    // Called at a negedge; returns at the negedge of the ISSUE cycle with valid dropped.
    task automatic wait_accept(input string tag, input int port);
        logic r = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            r = rdy_of(port);
            if (r) begin
                check({tag, "_other_rdy"}, 32'(rdy_of(1 - port)), 0);
                @(negedge clk);
                if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check({tag, "_accept_timeout"}, 32'(r), 1);
    endtask

    task automatic get_resp(input string tag, input int port, input logic [7:0] exp_p,
                            input logic exp_err, input int stall);
        logic       v  = 1'b0;
        logic [7:0] p;
        logic       e;
        for (int i = 0; i < 30; i++) begin
            v = rvld_of(port);
            if (v) break;
            @(negedge clk);
        end
        if (!v) begin
            check({tag, "_resp_timeout"}, 32'(v), 1);
            return;
        end
        check({tag, "_other_resp"}, 32'(rvld_of(1 - port)), 0);
        for (int s = 0; s < stall; s++) begin
            p = (port == 0) ? resp0_p : resp1_p;
            check({tag, "_stall_vld"}, 32'(rvld_of(port)), 1);
            check({tag, "_stall_p"}, 32'(p), 32'(exp_p));
            check({tag, "_stall_rdy"}, 32'({req0_ready, req1_ready}), 0);
            @(negedge clk);
        end
        p = (port == 0) ? resp0_p : resp1_p;
        e = (port == 0) ? resp0_err : resp1_err;
        check({tag, "_p"}, 32'(p), 32'(exp_p));
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        check({tag, "_drop"}, 32'(rvld_of(port)), 0);
    endtask

    initial begin
        int n;
        int exp_last;
        int mode, first;
        logic [3:0] m0, q0, m1, q1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        // Port 0 alone: 3 * -2 = -6
        raise(0, 4'h3, 4'hE);
        #1;
        check("p0_rdy", 32'(req0_ready), 1);
        wait_accept("p0", 0);
        check("p0_rdy_once", 32'(req0_ready), 0);
        check("p0_start", 32'(mul_start), 1);
        check("p0_mul_m", 32'(mul_m), 32'h3);
        check("p0_mul_q", 32'(mul_q), 32'hE);
        @(negedge clk);
        check("p0_start_pulse", 32'(mul_start), 0);
        get_resp("p0", 0, 8'hFA, 1'b0, 0);

        // Tie with last=0: port 1 wins, then port 0
        raise(0, 4'h3, 4'h3);
        wait_accept("solo", 0);
        get_resp("solo", 0, 8'h09, 1'b0, 0);
        raise(0, 4'h7, 4'hF);
        raise(1, 4'h2, 4'hD);
        wait_accept("tieA1", 1);
        get_resp("tieA1", 1, 8'hFA, 1'b0, 0);
        wait_accept("tieA0", 0);
        get_resp("tieA0", 0, 8'hF9, 1'b0, 0);

        // Backpressure: port 0 stalls 10 cycles while port 1 waits
        raise(0, 4'hD, 4'h4);
        wait_accept("stall0", 0);
        raise(1, 4'h6, 4'h2);
        get_resp("stall0", 0, 8'hF4, 1'b0, 10);
        wait_accept("stall1", 1);
        get_resp("stall1", 1, 8'h0C, 1'b0, 0);

        // Completion edge in the same cycle as the last allowed BUSY cycle: edge wins
        lat = 5;
        raise(0, 4'h5, 4'h3);
        wait_accept("edge_to", 0);
        get_resp("edge_to", 0, 8'h0F, 1'b0, 0);

        // Multiplier one cycle too slow: timeout
        lat = 6;
        raise(1, 4'h5, 4'h3);
        wait_accept("slow", 1);
        get_resp("slow", 1, 8'h00, 1'b1, 0);
        lat = 3;

        // Stuck-high valid: error after exactly 6 BUSY cycles
        stuck = 1'b1;
        raise(0, 4'h2, 4'h2);
        wait_accept("stuck", 0);
        check("stuck_start", 32'(mul_start), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (resp0_valid) break;
        end
        check("stuck_cycles", n, 7);
        get_resp("stuck", 0, 8'h00, 1'b1, 0);
        stuck = 1'b0;

        // Recovery after timeout
        raise(1, 4'h4, 4'h4);
        wait_accept("recover", 1);
        get_resp("recover", 1, 8'h10, 1'b0, 0);

        // Reset during BUSY, then a fresh request
        raise(0, 4'h6, 4'h6);
        wait_accept("rstmid", 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_quiet", all_outs(), 0);

        // First tie after reset: port 0 wins, then port 1
        raise(0, 4'h5, 4'h5);
        raise(1, 4'h8, 4'h8);
        #1;
        check("tieB_rdy1", 32'(req1_ready), 0);
        wait_accept("tieB0", 0);
        get_resp("tieB0", 0, 8'h19, 1'b0, 0);
        wait_accept("tieB1", 1);
        get_resp("tieB1", 1, 8'h40, 1'b0, 0);
        exp_last = 1;

        // Random operands and backpressure with round-robin order tracked by the bench
        for (int it = 0; it < 150; it++) begin
            m0 = 4'($urandom); q0 = 4'($urandom);
            m1 = 4'($urandom); q1 = 4'($urandom);
            mode = $urandom_range(0, 2);
            if (mode != 1) raise(0, m0, q0);
            if (mode != 0) raise(1, m1, q1);
            first = (mode == 2) ? 1 - exp_last : mode;
            wait_accept("rnd_a", first);
            get_resp("rnd_a", first, (first == 0) ? prod(m0, q0) : prod(m1, q1),
                     1'b0, $urandom_range(0, 2));
            exp_last = first;
            if (mode == 2) begin
                wait_accept("rnd_b", 1 - first);
                get_resp("rnd_b", 1 - first, (first == 0) ? prod(m1, q1) : prod(m0, q0),
                         1'b0, $urandom_range(0, 2));
                exp_last = 1 - first;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
